// File: rtl/validador_codigo.sv
// validador_codigo: access-code validator for the machine front panel.
// Tracks consecutive wrong submissions, locks the panel out for a fixed
// number of cycles after too many failures, and grants access on the
// correct code. All outputs are decoded from registered state only.
module validador_codigo #(
  parameter logic [6:0] CODIGO_CORRETO = 7'b0010001,
  parameter int         MAX_TENTATIVAS = 3,   // 1..3
  parameter int         T_BLOQUEIO     = 10   // 1..255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       power,
  input  logic [6:0] codigo,
  input  logic       confirma,
  output logic       acesso,
  output logic       bloqueado,
  output logic [1:0] tentativas,
  output logic [1:0] estado_val
);

  typedef enum logic [1:0] {
    DESLIGADO = 2'b00,
    ESPERA    = 2'b01,
    ACESSO    = 2'b10,
    BLOQUEIO  = 2'b11
  } estado_t;

  localparam logic [1:0] MAX_T = 2'(MAX_TENTATIVAS);
  localparam logic [7:0] T_BLQ = 8'(T_BLOQUEIO);

  estado_t    est, est_nxt;
  logic [1:0] tent, tent_nxt, tent_inc;
  logic [7:0] tmr, tmr_nxt;
  logic       conf_prev;
  logic       submit;

  // A submit is only the 0->1 transition of the button level.
  assign submit = confirma & ~conf_prev;

  // State, attempt counter, lockout timer and button history registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      est       <= DESLIGADO;
      tent      <= 2'd0;
      tmr       <= 8'd0;
      conf_prev <= 1'b0;
    end else begin
      est       <= est_nxt;
      tent      <= tent_nxt;
      tmr       <= tmr_nxt;
      conf_prev <= confirma;  // every cycle, every state: held button never resubmits
    end
  end

  // Next-state logic; power loss outranks a simultaneous submit.
  always_comb begin
    est_nxt  = est;
    tent_nxt = tent;
    tmr_nxt  = tmr;
    tent_inc = (tent == 2'b11) ? tent : tent + 2'd1;  // saturating increment
    case (est)
      DESLIGADO: begin
        if (power) est_nxt = ESPERA;
      end
      ESPERA: begin
        if (!power) begin
          est_nxt = DESLIGADO;            // attempt count deliberately kept
        end else if (submit) begin
          if (codigo == CODIGO_CORRETO) begin
            est_nxt  = ACESSO;
            tent_nxt = 2'd0;
          end else begin
            tent_nxt = tent_inc;
            if (tent_inc >= MAX_T) begin
              est_nxt = BLOQUEIO;
              tmr_nxt = T_BLQ;
            end
          end
        end
      end
      ACESSO: begin
        if (!power) est_nxt = DESLIGADO;
      end
      BLOQUEIO: begin
        // Timer runs regardless of power; the state is held for T_BLQ cycles.
        if (tmr <= 8'd1) begin
          tmr_nxt  = 8'd0;
          tent_nxt = 2'd0;
          est_nxt  = power ? ESPERA : DESLIGADO;
        end else begin
          tmr_nxt = tmr - 8'd1;
        end
      end
      default: est_nxt = DESLIGADO;
    endcase
  end

  assign acesso     = (est == ACESSO);
  assign bloqueado  = (est == BLOQUEIO);
  assign tentativas = tent;
  assign estado_val = est;

endmodule

// File: tb/tb_validador_codigo.sv
// Scoreboard bench for validador_codigo: the stimulus pushes the expected
// output snapshot for each clock edge; a monitor pops and compares.
module tb_validador_codigo;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       power = 1'b0;
  logic [6:0] codigo = 7'd0;
  logic       confirma = 1'b0;
  logic       acesso, bloqueado;
  logic [1:0] tentativas, estado_val;

  validador_codigo dut (
    .CLK(CLK), .RST(RST), .power(power), .codigo(codigo), .confirma(confirma),
    .acesso(acesso), .bloqueado(bloqueado), .tentativas(tentativas),
    .estado_val(estado_val)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         id;
    logic [1:0] st;
    logic [1:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_step = 0;
  bit   done   = 1'b0;

  localparam logic [6:0] OK  = 7'b0010001;
  localparam logic [6:0] BAD = 7'b0010011;

  // Monitor: every edge produces an output snapshot; compare it to the queue head.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (estado_val !== e.st || tentativas !== e.t ||
            acesso !== (e.st == 2'b10) || bloqueado !== (e.st == 2'b11)) begin
          errors++;
          $display("FAIL step%0d: got est=%b tent=%0d acesso=%b bloq=%b, want est=%b tent=%0d acesso=%b bloq=%b",
                   e.id, estado_val, tentativas, acesso, bloqueado,
                   e.st, e.t, (e.st == 2'b10), (e.st == 2'b11));
        end
      end
    end
  end

  // Apply inputs for one edge and record what the outputs must be after it.
  task automatic step(input logic rst, input logic pw, input logic [6:0] cd,
                      input logic cf, input logic [1:0] est, input logic [1:0] et);
    exp_t e;
    RST = rst; power = pw; codigo = cd; confirma = cf;
    @(posedge CLK);
    n_step++;
    e.id = n_step; e.st = est; e.t = et;
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  initial begin
    @(negedge CLK);
    // Reset state
    step(1, 0, OK, 0, 2'b00, 2'd0);
    step(1, 1, OK, 1, 2'b00, 2'd0);
    // Submit while off is ignored; power-on goes to ESPERA
    step(0, 0, OK, 0, 2'b00, 2'd0);
    step(0, 0, OK, 1, 2'b00, 2'd0);
    step(0, 1, OK, 1, 2'b01, 2'd0);   // held button: no new edge
    step(0, 1, OK, 0, 2'b01, 2'd0);
    // Correct code: access one cycle after the rise, further submits ignored
    step(0, 1, OK, 1, 2'b10, 2'd0);
    step(0, 1, OK, 0, 2'b10, 2'd0);
    step(0, 1, BAD, 1, 2'b10, 2'd0);
    step(0, 1, BAD, 0, 2'b10, 2'd0);
    step(0, 0, BAD, 0, 2'b00, 2'd0);
    // Three wrong codes -> lockout for 10 cycles -> ESPERA, count cleared
    step(0, 1, BAD, 0, 2'b01, 2'd0);
    step(0, 1, BAD, 1, 2'b01, 2'd1);
    step(0, 1, BAD, 0, 2'b01, 2'd1);
    step(0, 1, BAD, 1, 2'b01, 2'd2);
    step(0, 1, BAD, 0, 2'b01, 2'd2);
    step(0, 1, BAD, 1, 2'b11, 2'd3);
    for (int i = 0; i < 9; i++) step(0, 1, OK, 1'(i), 2'b11, 2'd3);  // submits ignored
    step(0, 1, OK, 0, 2'b01, 2'd0);
    // Count survives a power cycle
    step(0, 1, BAD, 1, 2'b01, 2'd1);
    step(0, 1, BAD, 0, 2'b01, 2'd1);
    step(0, 1, BAD, 1, 2'b01, 2'd2);
    step(0, 0, BAD, 0, 2'b00, 2'd2);
    step(0, 1, BAD, 0, 2'b01, 2'd2);
    step(0, 1, BAD, 1, 2'b11, 2'd3);
    for (int i = 0; i < 9; i++) step(0, 1, BAD, 0, 2'b11, 2'd3);
    step(0, 1, BAD, 0, 2'b01, 2'd0);
    // Power off during lockout: timer keeps running, ends in DESLIGADO
    step(0, 1, BAD, 1, 2'b01, 2'd1);
    step(0, 1, BAD, 0, 2'b01, 2'd1);
    step(0, 1, BAD, 1, 2'b01, 2'd2);
    step(0, 1, BAD, 0, 2'b01, 2'd2);
    step(0, 1, BAD, 1, 2'b11, 2'd3);
    for (int i = 0; i < 9; i++) step(0, 0, BAD, 0, 2'b11, 2'd3);
    step(0, 0, BAD, 0, 2'b00, 2'd0);
    // Held button for 20 cycles counts once
    step(0, 1, BAD, 0, 2'b01, 2'd0);
    for (int i = 0; i < 20; i++) step(0, 1, BAD, 1, 2'b01, 2'd1);
    step(0, 1, BAD, 0, 2'b01, 2'd1);
    // Power drop with simultaneous submit: power wins, count unchanged
    step(0, 0, BAD, 1, 2'b00, 2'd1);
    step(0, 1, BAD, 0, 2'b01, 2'd1);
    // Reset aborts a lockout
    step(0, 1, BAD, 1, 2'b01, 2'd2);
    step(0, 1, BAD, 0, 2'b01, 2'd2);
    step(0, 1, BAD, 1, 2'b11, 2'd3);
    step(0, 1, BAD, 0, 2'b11, 2'd3);
    step(0, 1, BAD, 0, 2'b11, 2'd3);
    step(1, 1, BAD, 0, 2'b00, 2'd0);
    step(0, 1, OK, 0, 2'b01, 2'd0);
    step(0, 1, OK, 1, 2'b10, 2'd0);
    step(0, 1, OK, 0, 2'b10, 2'd0);

    // Drain the scoreboard within a bounded time
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge CLK);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/validador_codigo.md
VALIDADOR_CODIGO -- requirements
Module: validador_codigo

Interface
REQ-001 Parameter: CODIGO_CORRETO, 7'b0010001, access code accepted by the machine.
REQ-002 Parameter: MAX_TENTATIVAS, 3, consecutive wrong submissions that trigger lockout (legal range 1..3).
REQ-003 Parameter: T_BLOQUEIO, 10, lockout duration in CLK cycles (legal range 1..255).
REQ-004 Port: CLK, in, 1, single system clock; all state updates on its rising edge.
REQ-005 Port: RST, in, 1, synchronous reset, active-high.
REQ-006 Port: power, in, 1, machine power switch; 1 = on.
REQ-007 Port: codigo, in, 7, code value presented by the user.
REQ-008 Port: confirma, in, 1, submit button as a level; the block detects its rising edge internally.
REQ-009 Port: acesso, out, 1, 1 = code accepted; enables the downstream circuito_eletrico to accept selecao/start.
REQ-010 Port: bloqueado, out, 1, 1 = lockout active.
REQ-011 Port: tentativas, out, 2, current count of consecutive wrong submissions.
REQ-012 Port: estado_val, out, 2, FSM state: 00 DESLIGADO, 01 ESPERA, 10 ACESSO, 11 BLOQUEIO.

Function
REQ-013 All outputs SHALL be registered or decoded only from registered state, with no combinational path from any input to any output.
REQ-014 Submit event SHALL be defined as: confirma=1 at a rising edge while the registered previous confirma=0.
REQ-015 The previous-confirma register SHALL update every cycle in every state, so a held confirma never produces a second submit.
REQ-016 DESLIGADO SHALL move to ESPERA at the first edge where power=1.
REQ-017 In ESPERA, a submit with codigo==CODIGO_CORRETO SHALL move to ACESSO at that same edge and clear tentativas to 0.
REQ-018 In ESPERA, a submit with a wrong code SHALL increment tentativas at that edge; if the new value equals MAX_TENTATIVAS, the FSM SHALL move to BLOQUEIO at that edge and load the lockout timer.
REQ-019 acesso SHALL be 1 exactly while estado_val=ACESSO; it is first seen high one cycle after the confirma rising edge.
REQ-020 In ACESSO, submits SHALL be ignored; the FSM SHALL leave ACESSO only when power=0.
REQ-021 In ESPERA or ACESSO, power=0 SHALL move the FSM to DESLIGADO at the next edge and deassert acesso.
REQ-022 Power-off SHALL NOT clear tentativas, so power cycling cannot bypass the attempt count.
REQ-023 If power=0 and a submit occur at the same edge, power SHALL take priority and the submit SHALL be discarded.
REQ-024 bloqueado SHALL be 1 for exactly T_BLOQUEIO consecutive cycles, beginning one cycle after the edge that enters BLOQUEIO.
REQ-025 All submits SHALL be ignored while in BLOQUEIO.
REQ-026 The lockout timer SHALL keep counting whether power is 1 or 0.
REQ-027 When the lockout timer expires, tentativas SHALL clear to 0 and the FSM SHALL go to ESPERA if power=1, or to DESLIGADO if power=0.
REQ-028 tentativas SHALL saturate and never wrap.
REQ-029 The lockout timer SHALL be 8 bits wide; T_BLOQUEIO values outside 1..255 are illegal.

Reset
REQ-030 RST=1 at a rising edge SHALL force estado_val=00, acesso=0, bloqueado=0, tentativas=0, lockout timer=0, and previous-confirma=0.
REQ-031 Reset SHALL take priority over all other inputs, including during BLOQUEIO, where it aborts the lockout.
REQ-032 After RST deasserts, operation SHALL resume from DESLIGADO using normal rules.

Verification
REQ-033 RST, then power=1, codigo=7'b0010001, pulse confirma -> estado_val 00->01->10; acesso=1 one cycle after the confirma rise; tentativas=0.
REQ-034 power=1, codigo=7'b0010011 submitted 3 times -> tentativas 1, 2, then BLOQUEIO; bloqueado=1 for exactly 10 cycles; then ESPERA with tentativas=0.
REQ-035 Two wrong submits, power 1->0->1, one more wrong submit -> BLOQUEIO entered, proving the count survives power-off.
REQ-036 Hold confirma=1 for 20 cycles with a wrong code -> tentativas=1 only.
REQ-037 Power=0 during BLOQUEIO -> bloqueado stays 1 for the full 10 cycles, then estado_val=00.
REQ-038 RST mid-BLOQUEIO -> next cycle all outputs are 0; power drop and submit at the same edge -> DESLIGADO with tentativas unchanged.
